vproc_cfg_unit: RTL and testbench

- Executes vsetvl/vsetvli/vsetivli requests from the decoder and holds the architectural vector configuration: vsew, lmul, vta/vma, vl, vill.
- Successor to the fixed 32-bit config path: generalised over vector register width (VREG_W), ELEN of 32 or 64, and XLEN.
- Adds vill detection, clamped keep-vl semantics and a back-pressured result port that returns the new vl to the scalar core.
- Sits between the decoder and the dispatcher; all other units read its registered config outputs.

---
 rtl/vproc_cfg_unit_pkg.sv | 64 ++++++
 rtl/vproc_vlmax_calc.sv | 46 ++++
 rtl/vproc_cfg_unit.sv | 184 ++++++++++++++++++
 tb/tb_vproc_cfg_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/vproc_cfg_unit_pkg.sv
// Shared types for the vector configuration unit and its consumers.
package vproc_cfg_unit_pkg;

    // SEW encoding; VSEW_64 is only legal when ELEN=64.
    typedef enum logic [1:0] {
        VSEW_8  = 2'b00,
        VSEW_16 = 2'b01,
        VSEW_32 = 2'b10,
        VSEW_64 = 2'b11
    } cfg_vsew_e;

    // LMUL encoding: 0..3 integer, 5..7 fractional (1/8, 1/4, 1/2).
    typedef enum logic [2:0] {
        LMUL_1       = 3'b000,
        LMUL_2       = 3'b001,
        LMUL_4       = 3'b010,
        LMUL_8       = 3'b011,
        LMUL_INVALID = 3'b100,
        LMUL_F8      = 3'b101,
        LMUL_F4      = 3'b110,
        LMUL_F2      = 3'b111
    } cfg_lmul_e;

    // Widths carried by the request struct; these must match the unit's
    // XLEN and ID_W parameters.
    localparam int unsigned CFG_XLEN = 32;
    localparam int unsigned CFG_ID_W = 5;

    // Architectural configuration (vl is held separately, it is VL_W wide).
    typedef struct packed {
        cfg_vsew_e  vsew;
        cfg_lmul_e  lmul;
        logic [1:0] agnostic;  // {vma, vta}
        logic       vill;
    } cfg_state_t;

    // Decoded configuration operation.
    typedef struct packed {
        cfg_vsew_e  vsew;
        cfg_lmul_e  lmul;
        logic [1:0] agnostic;
        logic       vlmax;
        logic       keep_vl;
    } op_mode_cfg_t;

    typedef struct packed {
        op_mode_cfg_t          mode;
        logic [CFG_XLEN-1:0]   avl;
        logic [CFG_ID_W-1:0]   id;
    } cfg_req_t;

    // Reset state doubles as the result of an illegal request.
    localparam cfg_state_t CFG_STATE_ILL = '{
        vsew:     VSEW_8,
        lmul:     LMUL_1,
        agnostic: 2'b00,
        vill:     1'b1
    };

    function automatic logic [31:0] sew_bits(input cfg_vsew_e v);
        return 32'd8 << v;
    endfunction

endpackage

// File: rtl/vproc_vlmax_calc.sv
// Combinational VLMAX and legality for a (vsew, lmul) pair.
module vproc_vlmax_calc
    import vproc_cfg_unit_pkg::*;
#(
    parameter int unsigned VREG_W = 128,
    parameter int unsigned ELEN   = 32,
    parameter int unsigned VL_W   = $clog2(VREG_W) + 1
) (
    input  cfg_vsew_e         vsew_i,
    input  cfg_lmul_e         lmul_i,
    output logic [VL_W-1:0]   vlmax_o,
    output logic              illegal_o
);

    logic [31:0]     sew;
    logic [VL_W-1:0] per_reg;
    logic [VL_W-1:0] vlmax_raw;
    logic [3:0]      frac_sh;
    logic            frac_bad;

    // VLMAX = (VREG_W/SEW) scaled by LMUL; illegal configs force VLMAX to 0.
    always_comb begin
        sew       = sew_bits(vsew_i);
        per_reg   = VL_W'(VREG_W) >> (4'd3 + {2'b00, vsew_i});
        frac_sh   = 4'd8 - {1'b0, lmul_i};
        vlmax_raw = '0;
        frac_bad  = 1'b0;
        case (lmul_i)
            LMUL_1, LMUL_2, LMUL_4, LMUL_8: begin
                vlmax_raw = per_reg << lmul_i[1:0];
            end
            LMUL_F8, LMUL_F4, LMUL_F2: begin
                vlmax_raw = per_reg >> frac_sh;
                // SEW > ELEN*LMUL, rearranged to avoid fractions
                frac_bad  = (sew << frac_sh) > 32'(ELEN);
            end
            default: vlmax_raw = '0;
        endcase
        illegal_o = ((vsew_i == VSEW_64) && (ELEN == 32)) ||
                    (lmul_i == LMUL_INVALID) ||
                    frac_bad ||
                    (vlmax_raw == '0);
        vlmax_o   = illegal_o ? '0 : vlmax_raw;
    end

endmodule

// File: rtl/vproc_cfg_unit.sv
// Executes vsetvl-family requests and holds the architectural vector config.
module vproc_cfg_unit
    import vproc_cfg_unit_pkg::*;
#(
    parameter int unsigned VREG_W = 128,
    parameter int unsigned ELEN   = 32,
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ID_W   = 5,
    parameter int unsigned VL_W   = $clog2(VREG_W) + 1
) (
    input  logic              clk_i,
    input  logic              sync_rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [1:0]        req_vsew_i,
    input  logic [2:0]        req_lmul_i,
    input  logic [1:0]        req_agnostic_i,
    input  logic              req_vlmax_i,
    input  logic              req_keep_vl_i,
    input  logic [XLEN-1:0]   req_avl_i,
    input  logic [ID_W-1:0]   req_id_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [XLEN-1:0]   res_vl_o,
    output logic [ID_W-1:0]   res_id_o,
    output logic [1:0]        cfg_vsew_o,
    output logic [2:0]        cfg_lmul_o,
    output logic [1:0]        cfg_agnostic_o,
    output logic              cfg_vill_o,
    output logic [VL_W-1:0]   cfg_vl_o,
    output logic [VL_W-1:0]   cfg_vlmax_o,
    output logic [VL_W-1:0]   cfg_evl_mask_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_UPD,
        ST_RESP
    } state_e;

    state_e          state_q, state_d;
    cfg_req_t        req_q, req_d;
    logic [VL_W-1:0] vlmax_q, vlmax_d;
    logic            illegal_q, illegal_d;
    logic [VL_W-1:0] pend_vl_q, pend_vl_d;
    cfg_state_t      cfg_q, cfg_d;
    logic [VL_W-1:0] vl_q, vl_d;
    logic [VL_W-1:0] cfg_vlmax_q, cfg_vlmax_d;
    logic [VL_W-1:0] evl_q, evl_d;
    logic            res_valid_q, res_valid_d;

    logic [VL_W-1:0] calc_vlmax;
    logic            calc_illegal;
    logic [XLEN-1:0] avl;
    logic [VL_W-1:0] new_vl;

    vproc_vlmax_calc #(
        .VREG_W (VREG_W),
        .ELEN   (ELEN),
        .VL_W   (VL_W)
    ) u_vlmax_calc (
        .vsew_i    (req_q.mode.vsew),
        .lmul_i    (req_q.mode.lmul),
        .vlmax_o   (calc_vlmax),
        .illegal_o (calc_illegal)
    );

    // New vl selection; vlmax beats keep_vl, AVL compared at full XLEN width.
    always_comb begin
        avl    = XLEN'(req_q.avl);
        new_vl = '0;
        if (illegal_q) begin
            new_vl = '0;
        end else if (req_q.mode.vlmax) begin
            new_vl = vlmax_q;
        end else if (req_q.mode.keep_vl) begin
            // an illegal old config has no meaningful vl to keep
            new_vl = cfg_q.vill ? '0 : ((vl_q < vlmax_q) ? vl_q : vlmax_q);
        end else begin
            new_vl = (avl < XLEN'(vlmax_q)) ? VL_W'(avl) : vlmax_q;
        end
    end

    // Next-state and handshake logic.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        vlmax_d     = vlmax_q;
        illegal_d   = illegal_q;
        pend_vl_d   = pend_vl_q;
        cfg_d       = cfg_q;
        vl_d        = vl_q;
        cfg_vlmax_d = cfg_vlmax_q;
        evl_d       = evl_q;
        res_valid_d = res_valid_q;
        req_ready_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    req_d.mode.vsew     = cfg_vsew_e'(req_vsew_i);
                    req_d.mode.lmul     = cfg_lmul_e'(req_lmul_i);
                    req_d.mode.agnostic = req_agnostic_i;
                    req_d.mode.vlmax    = req_vlmax_i;
                    req_d.mode.keep_vl  = req_keep_vl_i;
                    req_d.avl           = CFG_XLEN'(req_avl_i);
                    req_d.id            = CFG_ID_W'(req_id_i);
                    state_d             = ST_CALC;
                end
            end
            ST_CALC: begin
                vlmax_d   = calc_vlmax;
                illegal_d = calc_illegal;
                state_d   = ST_UPD;
            end
            ST_UPD: begin
                pend_vl_d = new_vl;
                state_d   = ST_RESP;
            end
            ST_RESP: begin
                // First RESP cycle commits the staged result; the response is
                // offered from the next cycle on, three edges after acceptance.
                if (!res_valid_q) begin
                    if (illegal_q) begin
                        cfg_d = CFG_STATE_ILL;
                    end else begin
                        cfg_d.vsew     = req_q.mode.vsew;
                        cfg_d.lmul     = req_q.mode.lmul;
                        cfg_d.agnostic = req_q.mode.agnostic;
                        cfg_d.vill     = 1'b0;
                    end
                    vl_d        = pend_vl_q;
                    cfg_vlmax_d = vlmax_q;
                    evl_d       = (pend_vl_q + VL_W'(7)) >> 3;
                    res_valid_d = 1'b1;
                end else if (res_ready_i) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!sync_rst_ni) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            vlmax_q     <= '0;
            illegal_q   <= 1'b0;
            pend_vl_q   <= '0;
            cfg_q       <= CFG_STATE_ILL;
            vl_q        <= '0;
            cfg_vlmax_q <= '0;
            evl_q       <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            vlmax_q     <= vlmax_d;
            illegal_q   <= illegal_d;
            pend_vl_q   <= pend_vl_d;
            cfg_q       <= cfg_d;
            vl_q        <= vl_d;
            cfg_vlmax_q <= cfg_vlmax_d;
            evl_q       <= evl_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign res_valid_o    = res_valid_q;
    assign res_vl_o       = XLEN'(vl_q);
    assign res_id_o       = ID_W'(req_q.id);
    assign cfg_vsew_o     = cfg_q.vsew;
    assign cfg_lmul_o     = cfg_q.lmul;
    assign cfg_agnostic_o = cfg_q.agnostic;
    assign cfg_vill_o     = cfg_q.vill;
    assign cfg_vl_o       = vl_q;
    assign cfg_vlmax_o    = cfg_vlmax_q;
    assign cfg_evl_mask_o = evl_q;

endmodule

// File: tb/tb_vproc_cfg_unit.sv
// Directed bench for vproc_cfg_unit at VREG_W=128, ELEN=32.
module tb_vproc_cfg_unit;

    localparam int XLEN = 32;
    localparam int ID_W = 5;
    localparam int VL_W = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [1:0]      req_vsew = '0;
    logic [2:0]      req_lmul = '0;
    logic [1:0]      req_agn = '0;
    logic            req_vmax = 1'b0;
    logic            req_keep = 1'b0;
    logic [XLEN-1:0] req_avl = '0;
    logic [ID_W-1:0] req_id = '0;
    logic            res_valid;
    logic            res_ready = 1'b0;
    logic [XLEN-1:0] res_vl;
    logic [ID_W-1:0] res_id;
    logic [1:0]      cfg_vsew;
    logic [2:0]      cfg_lmul;
    logic [1:0]      cfg_agn;
    logic            cfg_vill;
    logic [VL_W-1:0] cfg_vl;
    logic [VL_W-1:0] cfg_vlmax;
    logic [VL_W-1:0] cfg_evl;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vproc_cfg_unit #(
        .VREG_W (128),
        .ELEN   (32),
        .XLEN   (XLEN),
        .ID_W   (ID_W),
        .VL_W   (VL_W)
    ) dut (
        .clk_i          (clk),
        .sync_rst_ni    (rst_n),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_vsew_i     (req_vsew),
        .req_lmul_i     (req_lmul),
        .req_agnostic_i (req_agn),
        .req_vlmax_i    (req_vmax),
        .req_keep_vl_i  (req_keep),
        .req_avl_i      (req_avl),
        .req_id_i       (req_id),
        .res_valid_o    (res_valid),
        .res_ready_i    (res_ready),
        .res_vl_o       (res_vl),
        .res_id_o       (res_id),
        .cfg_vsew_o     (cfg_vsew),
        .cfg_lmul_o     (cfg_lmul),
        .cfg_agnostic_o (cfg_agn),
        .cfg_vill_o     (cfg_vill),
        .cfg_vl_o       (cfg_vl),
        .cfg_vlmax_o    (cfg_vlmax),
        .cfg_evl_mask_o (cfg_evl)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cfg(input string tag, input logic vill, input logic [1:0] vsew,
                           input logic [2:0] lmul, input logic [1:0] agn);
        chk({tag, "/vill"}, cfg_vill, vill);
        chk({tag, "/vsew"}, cfg_vsew, vsew);
        chk({tag, "/lmul"}, cfg_lmul, lmul);
        chk({tag, "/agn"},  cfg_agn,  agn);
    endtask

    // Issue one request, check latency/response/stall, consume, check vl.
    task automatic do_req(input string tag, input logic [1:0] vsew, input logic [2:0] lmul,
                          input logic [1:0] agn, input logic vmax, input logic keep,
                          input logic [31:0] avl, input logic [4:0] id, input int stall,
                          input logic [31:0] exp_vl);
        bit acc = 1'b0;
        int lat = 0;
        req_vsew = vsew; req_lmul = lmul; req_agn = agn;
        req_vmax = vmax; req_keep = keep; req_avl = avl; req_id = id;
        req_valid = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) begin
            acc = req_ready;
            step();
        end
        req_valid = 1'b0;
        chk({tag, "/accept"}, acc, 1);
        while (!res_valid && lat < 20) begin
            step();
            lat++;
        end
        chk({tag, "/latency"}, lat, 3);
        chk({tag, "/res_vl"}, res_vl, exp_vl);
        chk({tag, "/res_id"}, res_id, id);
        for (int i = 0; i < stall; i++) begin
            step();
            chk({tag, "/stall_valid"}, res_valid, 1);
            chk({tag, "/stall_vl"}, res_vl, exp_vl);
            chk({tag, "/stall_id"}, res_id, id);
            chk({tag, "/stall_ready"}, req_ready, 0);
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk({tag, "/valid_drop"}, res_valid, 0);
        chk({tag, "/cfg_vl"}, cfg_vl, exp_vl);
    endtask

    initial begin
        int rises;
        int wait_cyc;
        bit acc;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (5) step();
        chk("rst/vill", cfg_vill, 1);
        chk("rst/vl", cfg_vl, 0);
        chk("rst/vlmax", cfg_vlmax, 0);
        chk("rst/res_valid", res_valid, 0);
        chk("rst/req_ready", req_ready, 1);
        chk("rst/vsew", cfg_vsew, 0);

        do_req("e32m2", 2'd2, 3'd1, 2'd0, 0, 0, 10, 5'h11, 0, 8);
        chk_cfg("e32m2", 0, 2'd2, 3'd1, 2'd0);
        chk("e32m2/vlmax", cfg_vlmax, 8);
        chk("e32m2/evl", cfg_evl, 1);

        do_req("e8mf2", 2'd0, 3'd7, 2'd1, 0, 0, 5, 5'h02, 0, 5);
        chk_cfg("e8mf2", 0, 2'd0, 3'd7, 2'd1);
        chk("e8mf2/vlmax", cfg_vlmax, 8);
        chk("e8mf2/evl", cfg_evl, 1);

        do_req("keep_e16m1", 2'd1, 3'd0, 2'd0, 0, 1, 100, 5'h03, 0, 5);
        do_req("keep_clamp", 2'd2, 3'd0, 2'd0, 0, 1, 100, 5'h04, 0, 4);
        chk("keep_clamp/vlmax", cfg_vlmax, 4);

        do_req("vmax_over_keep", 2'd0, 3'd0, 2'd0, 1, 1, 1, 5'h05, 0, 16);

        do_req("vmax_e8m8", 2'd0, 3'd3, 2'd3, 1, 0, 0, 5'h06, 0, 128);
        chk_cfg("vmax_e8m8", 0, 2'd0, 3'd3, 2'd3);
        chk("vmax_e8m8/vlmax", cfg_vlmax, 128);
        chk("vmax_e8m8/evl", cfg_evl, 16);

        do_req("avl_wide", 2'd0, 3'd0, 2'd0, 0, 0, 32'h8000_0003, 5'h07, 0, 16);
        do_req("avl_zero", 2'd0, 3'd0, 2'd0, 0, 0, 0, 5'h08, 0, 0);
        chk("avl_zero/vill", cfg_vill, 0);
        chk("avl_zero/evl", cfg_evl, 0);

        do_req("e8mf4", 2'd0, 3'd6, 2'd0, 0, 0, 9, 5'h09, 0, 4);
        chk("e8mf4/vill", cfg_vill, 0);
        chk("e8mf4/vlmax", cfg_vlmax, 4);

        do_req("ill_e32mf8", 2'd2, 3'd5, 2'd3, 0, 0, 10, 5'h0a, 0, 0);
        chk_cfg("ill_e32mf8", 1, 2'd0, 3'd0, 2'd0);

        do_req("keep_vill", 2'd0, 3'd0, 2'd0, 0, 1, 50, 5'h0b, 0, 0);
        chk("keep_vill/vill", cfg_vill, 0);

        do_req("ill_e64", 2'd3, 3'd0, 2'd0, 0, 0, 4, 5'h0c, 0, 0);
        chk_cfg("ill_e64", 1, 2'd0, 3'd0, 2'd0);

        do_req("ill_lmul4", 2'd0, 3'd4, 2'd0, 0, 0, 4, 5'h0d, 0, 0);
        chk_cfg("ill_lmul4", 1, 2'd0, 3'd0, 2'd0);

        do_req("ill_e16mf4", 2'd1, 3'd6, 2'd0, 0, 0, 4, 5'h0e, 0, 0);
        chk("ill_e16mf4/vill", cfg_vill, 1);

        do_req("stall", 2'd1, 3'd1, 2'd0, 0, 0, 7, 5'h0f, 4, 7);
        chk("stall/vlmax", cfg_vlmax, 16);

        // reset while a response is pending
        req_vsew = 2'd0; req_lmul = 3'd0; req_agn = 2'd0;
        req_vmax = 1'b0; req_keep = 1'b0; req_avl = 9; req_id = 5'h10;
        req_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            acc = req_ready;
            step();
        end
        req_valid = 1'b0;
        chk("rst_resp/accept", acc, 1);
        wait_cyc = 0;
        while (!res_valid && wait_cyc < 20) begin
            step();
            wait_cyc++;
        end
        chk("rst_resp/valid_seen", res_valid, 1);
        rst_n = 1'b0;
        step();
        chk("rst_resp/valid", res_valid, 0);
        chk("rst_resp/vill", cfg_vill, 1);
        chk("rst_resp/vl", cfg_vl, 0);
        rst_n = 1'b1;
        res_ready = 1'b1;
        rises = 0;
        repeat (8) begin
            step();
            if (res_valid) rises++;
        end
        res_ready = 1'b0;
        chk("rst_resp/no_resp", rises, 0);
        chk("rst_resp/ready", req_ready, 1);

        do_req("after_rst", 2'd0, 3'd0, 2'd0, 0, 0, 3, 5'h11, 0, 3);
        chk("after_rst/vill", cfg_vill, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
